uart_rx_oversampled: RTL and testbench
======================================

# uart_rx_oversampled

Parametrised, oversampling UART receiver: the next generation of the team's fixed-8-bit receiver. It adds run-time frame format (5..DATA_SIZE data bits, none/even/odd parity, 1 or 2 stop bits), an external baud-tick enable, an input synchroniser and a valid/ready output register with overflow detection. It sits between the serial pin and the receive FIFO/status register of the UART peripheral.

## Interface
- DATA_SIZE, 8, maximum data bits per frame; legal range 5..9
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8
- SYNC_STAGES, 2, flops in the serial_data_in synchroniser; must be >= 2
- clk  input  1  sole clock
- reset  input  1  asynchronous, active-high reset
- sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud; all bit timing advances only on this
- serial_data_in  input  1  asynchronous serial line, idle high
- cfg_data_bits  input  4  data bits per frame, 5..DATA_SIZE; out-of-range values are treated as DATA_SIZE
- cfg_parity_en  input  1  1 = a parity bit follows the data
- cfg_parity_odd  input  1  1 = odd parity, 0 = even parity
- cfg_two_stop  input  1  1 = two stop bits are checked
- rx_ready  input  1  consumer accepts data_out this cycle
- data_out  output  DATA_SIZE  received word, LSB-aligned, unused upper bits 0
- rx_valid  output  1  data_out and error flags are valid
- parity_error  output  1  frame parity mismatch; qualified by rx_valid
- stop_error  output  1  a stop bit was sampled low (not a break); qualified by rx_valid
- break_error  output  1  break frame; qualified by rx_valid
- overflow_error  output  1  one-clk pulse when a completed frame is dropped
- rx_busy  output  1  high in every state except IDLE

## Operation
- The serial_data_in synchroniser flops reset to 1. All decisions use the synchronised line (rxd).
- The sample counter runs 0..OVERSAMPLE-1. It advances only on sample_tick and wraps to 0.
- IDLE: on a tick with rxd=0, clear the counter and go to START. Latch the cfg_* inputs at this point; they are ignored for the rest of the frame.
- START: on the tick at count OVERSAMPLE/2-1, the sampled bit decides the next state. If it is 1, treat the low as a glitch and return to IDLE. If it is 0, clear the counter, clear the bit counter and go to DATA.
- DATA: sample a bit on the tick at count OVERSAMPLE-1 and shift it in LSB first. After cfg_data_bits bits, go to PARITY if parity is enabled, otherwise go to STOP.
- PARITY: sample one bit. parity_error = XOR(data bits, parity bit) != cfg_parity_odd.
- STOP: sample the stop bit, and the second stop bit when cfg_two_stop=1. On the final stop sample, the frame completes.
- Break: all data bits, the parity bit (if present) and the first stop bit are 0. The frame then completes with break_error=1, stop_error=0, parity_error=0 and data_out=0. The FSM goes to BRK_WAIT and stays there until a tick with rxd=1, then goes to IDLE.
- Any other low stop bit: stop_error=1, then go to IDLE.
- Good frame: go to IDLE directly after the final stop sample, at mid-bit, to allow immediate resync.
- Output register: a completed frame loads data_out and the three error flags together, and sets rx_valid.
- rx_valid clears on the cycle after a clk where rx_valid && rx_ready.
- Overflow: a frame completes while rx_valid=1 and rx_ready=0. The old word and flags are kept, the new frame is discarded, and overflow_error pulses for 1 clk.
- Simultaneous completion and pop (rx_valid && rx_ready): the new frame loads, rx_valid stays 1 and there is no overflow.
- Reset asserted mid-frame: the FSM goes to IDLE immediately and all counters and outputs return to their reset values. A frame in flight is lost.

## Timing
- Reset values: data_out=0, rx_valid=0, parity_error=0, stop_error=0, break_error=0, overflow_error=0, rx_busy=0; FSM in IDLE.
- Input latency: SYNC_STAGES clks from a pin edge to rxd.
- Completion latency: rx_valid and the error flags rise on the clk edge after the clk carrying the final stop-bit sample tick.
- overflow_error rises at that same edge and lasts exactly 1 clk.
- A frame takes OVERSAMPLE/2 + OVERSAMPLE × (data + parity + stop) ticks from start detection to completion.
- sample_tick held high continuously is legal: the block then oversamples at clk rate.

## Configuration
- Macro UART_RX_MAJORITY_EN.
- Defined: the block keeps a 3-entry history of rxd captured on ticks. Each bit decision (start validation, data, parity, stop, BRK_WAIT exit) uses the majority of the last three tick samples. A single-tick glitch therefore cannot flip a bit.
- Undefined: each decision uses the single rxd value at the decision tick; the history register is not built.

## Test plan
- 8N1, OVERSAMPLE=16, byte 0xA5, rx_ready=1 -> one rx_valid pulse, data_out=0xA5, all error flags 0.
- 7E1 frame with data 0x41 and parity bit driven 1 -> rx_valid with data_out=0x41 and parity_error=1; the next good frame 0x42 shows parity_error=0.
- Line held low for 12 bit times, then high -> one frame with break_error=1 and data_out=0x00; no further frame is reported until the line has returned high.
- Two 8N1 frames 0x11 then 0x22 with rx_ready=0 -> overflow_error pulses 1 clk after the second frame, data_out stays 0x11. Raising rx_ready on the completion cycle of a third frame 0x33 loads 0x33 with no overflow.
- Line low for 4 ticks, then high -> FSM returns to IDLE, rx_valid never asserts; reset asserted mid-DATA -> all outputs 0 on the next observation.
- 1-tick low glitch at the sampling tick of bit 3 of 0xFF -> with UART_RX_MAJORITY_EN, data_out=0xFF; without it, data_out=0xF7.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: synchronised line, run-time frame format, valid/ready output word.
// Latency: SYNC_STAGES clks pin-to-rxd; outputs load on the edge of the final stop-bit sample tick.
// Backpressure: one-word output register; a frame completing while the word is unread is dropped
//    and overflow_error pulses for one clk.
//
// Ports:
//   clk, reset            sole clock, asynchronous active-high reset
//   sample_tick           OVERSAMPLE x baud enable; all bit timing advances on it
//   serial_data_in        asynchronous serial line, idle high
//   cfg_*                 frame format, latched at start-bit detection
//   rx_ready              consumer pops data_out
//   data_out, rx_valid    received word (LSB-aligned) and its valid flag
//   parity_error, stop_error, break_error   per-word flags, qualified by rx_valid
//   overflow_error        one-clk pulse on a dropped frame
//   rx_busy               FSM not in IDLE
//
// Optional feature: define UART_RX_MAJORITY_EN to take every bit decision as the majority of the
// last three tick samples of rxd.
module uart_rx_oversampled #(
   parameter int DATA_SIZE   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_tick,
   input  logic                 serial_data_in,
   input  logic [3:0]           cfg_data_bits,
   input  logic                 cfg_parity_en,
   input  logic                 cfg_parity_odd,
   input  logic                 cfg_two_stop,
   input  logic                 rx_ready,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 rx_valid,
   output logic                 parity_error,
   output logic                 stop_error,
   output logic                 break_error,
   output logic                 overflow_error,
   output logic                 rx_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
   localparam logic [3:0]    DS4      = 4'(DATA_SIZE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BRK_WAIT
   } state_t;

   // ---------------- input synchroniser ----------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], serial_data_in};
      end
   end

   assign rxd = sync_q[SYNC_STAGES-1];

   // ---------------- bit decision value ----------------
   logic bit_val;

`ifdef UART_RX_MAJORITY_EN
   // Two previous tick samples; together with the current rxd they form the 3-sample window.
   logic [1:0] hist_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= 2'b11;
      end else if (sample_tick) begin
         hist_q <= {hist_q[0], rxd};
      end
   end

   assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd) | (hist_q[0] & rxd);
`else
   assign bit_val = rxd;
`endif

   // ---------------- frame state ----------------
   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [3:0]             bit_cnt_q;
   logic [3:0]             nbits_q;
   logic                   par_en_q;
   logic                   par_odd_q;
   logic                   two_stop_q;
   logic                   stop2_q;     // currently sampling the second stop bit
   logic [DATA_SIZE-1:0]   shreg_q;
   logic                   par_acc_q;   // running XOR of data bits
   logic                   zero_q;      // every bit so far sampled low (break candidate)
   logic                   fperr_q;
   logic                   fserr_q;

   logic [DATA_SIZE-1:0]   data_out_q;
   logic                   rx_valid_q;
   logic                   parity_error_q;
   logic                   stop_error_q;
   logic                   break_error_q;
   logic                   overflow_q;

   logic [3:0]             cfg_bits_d;
   logic                   done_d;
   logic                   done_brk_d;
   logic                   done_serr_d;

   // Out-of-range data widths fall back to the maximum.
   assign cfg_bits_d = (cfg_data_bits < 4'd5 || cfg_data_bits > DS4) ? DS4 : cfg_data_bits;

   // Frame completion is decided on the final stop sample; a break completes on the first one.
   always_comb begin
      done_d      = 1'b0;
      done_brk_d  = 1'b0;
      done_serr_d = 1'b0;
      if (sample_tick && state_q == S_STOP && cnt_q == CNT_END) begin
         if (!stop2_q && !bit_val && zero_q) begin
            done_d     = 1'b1;
            done_brk_d = 1'b1;
         end else if (stop2_q || !two_stop_q) begin
            done_d      = 1'b1;
            done_serr_d = fserr_q | ~bit_val;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         bit_cnt_q      <= '0;
         nbits_q        <= DS4;
         par_en_q       <= 1'b0;
         par_odd_q      <= 1'b0;
         two_stop_q     <= 1'b0;
         stop2_q        <= 1'b0;
         shreg_q        <= '0;
         par_acc_q      <= 1'b0;
         zero_q         <= 1'b0;
         fperr_q        <= 1'b0;
         fserr_q        <= 1'b0;
         data_out_q     <= '0;
         rx_valid_q     <= 1'b0;
         parity_error_q <= 1'b0;
         stop_error_q   <= 1'b0;
         break_error_q  <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         // ---- output register ----
         overflow_q <= 1'b0;
         if (done_d) begin
            if (!rx_valid_q || rx_ready) begin
               data_out_q     <= done_brk_d ? '0 : shreg_q;
               parity_error_q <= done_brk_d ? 1'b0 : fperr_q;
               stop_error_q   <= done_serr_d;
               break_error_q  <= done_brk_d;
               rx_valid_q     <= 1'b1;
            end else begin
               overflow_q <= 1'b1;
            end
         end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end

         // ---- bit timing FSM ----
         if (sample_tick) begin
            cnt_q <= (cnt_q == CNT_END) ? '0 : cnt_q + 1'b1;
            case (state_q)
               S_IDLE: begin
                  if (!rxd) begin
                     cnt_q      <= '0;
                     nbits_q    <= cfg_bits_d;
                     par_en_q   <= cfg_parity_en;
                     par_odd_q  <= cfg_parity_odd;
                     two_stop_q <= cfg_two_stop;
                     state_q    <= S_START;
                  end
               end
               S_START: begin
                  if (cnt_q == CNT_HALF) begin
                     if (bit_val) begin
                        state_q <= S_IDLE;
                     end else begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        shreg_q   <= '0;
                        par_acc_q <= 1'b0;
                        zero_q    <= 1'b1;
                        fperr_q   <= 1'b0;
                        fserr_q   <= 1'b0;
                        stop2_q   <= 1'b0;
                        state_q   <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (cnt_q == CNT_END) begin
                     for (int i = 0; i < DATA_SIZE; i++) begin
                        if (bit_cnt_q == 4'(i)) shreg_q[i] <= bit_val;
                     end
                     par_acc_q <= par_acc_q ^ bit_val;
                     zero_q    <= zero_q & ~bit_val;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == nbits_q - 4'd1) begin
                        state_q <= par_en_q ? S_PARITY : S_STOP;
                     end
                  end
               end
               S_PARITY: begin
                  if (cnt_q == CNT_END) begin
                     fperr_q <= (par_acc_q ^ bit_val) != par_odd_q;
                     zero_q  <= zero_q & ~bit_val;
                     state_q <= S_STOP;
                  end
               end
               S_STOP: begin
                  if (cnt_q == CNT_END) begin
                     if (done_brk_d) begin
                        state_q <= S_BRK_WAIT;
                     end else if (done_d) begin
                        // Leave at mid stop bit so the next start edge is caught at once.
                        state_q <= S_IDLE;
                     end else begin
                        fserr_q <= ~bit_val;
                        stop2_q <= 1'b1;
                     end
                  end
               end
               S_BRK_WAIT: begin
                  if (bit_val) state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign data_out       = data_out_q;
   assign rx_valid       = rx_valid_q;
   assign parity_error   = parity_error_q;
   assign stop_error     = stop_error_q;
   assign break_error    = break_error_q;
   assign overflow_error = overflow_q;
   assign rx_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled (DATA_SIZE=8, OVERSAMPLE=16).
// Frames are driven tick by tick; received words are collected at negedge on every pop.
module tb_uart_rx_oversampled;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       sample_tick;
   logic       serial_data_in;
   logic [3:0] cfg_data_bits;
   logic       cfg_parity_en;
   logic       cfg_parity_odd;
   logic       cfg_two_stop;
   logic       rx_ready;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       parity_error;
   logic       stop_error;
   logic       break_error;
   logic       overflow_error;
   logic       rx_busy;

   typedef struct packed {
      logic [7:0] dat;
      logic       perr;
      logic       serr;
      logic       brk;
   } rec_t;

   typedef struct {
      logic [3:0] cfg_bits;
      int         nbits;
      logic [7:0] dat;
      bit         pen;
      bit         odd;
      bit         two;
      bit         pb;
      bit         stopb;
      rec_t       exp;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   tdiv = 4;
   int   tdc = 0;
   int   ovf_cnt = 0;
   rec_t got_q[$];
   bit   txq[$];
   vec_t vecs[10];

   uart_rx_oversampled dut (
      .clk            (clk),
      .reset          (reset),
      .sample_tick    (sample_tick),
      .serial_data_in (serial_data_in),
      .cfg_data_bits  (cfg_data_bits),
      .cfg_parity_en  (cfg_parity_en),
      .cfg_parity_odd (cfg_parity_odd),
      .cfg_two_stop   (cfg_two_stop),
      .rx_ready       (rx_ready),
      .data_out       (data_out),
      .rx_valid       (rx_valid),
      .parity_error   (parity_error),
      .stop_error     (stop_error),
      .break_error    (break_error),
      .overflow_error (overflow_error),
      .rx_busy        (rx_busy)
   );

   always #5 clk = ~clk;

   // Tick generator: one pulse every tdiv clks.
   initial begin
      sample_tick = 1'b0;
      forever begin
         @(negedge clk);
         tdc++;
         if (tdc >= tdiv) begin
            tdc = 0;
            sample_tick = 1'b1;
         end else begin
            sample_tick = 1'b0;
         end
      end
   end

   // Output monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && rx_valid && rx_ready)
            got_q.push_back({data_out, parity_error, stop_error, break_error});
         if (overflow_error) ovf_cnt++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   // Reference: frame fields from the protocol rules.
   function automatic rec_t model(logic [7:0] d, int n, bit pen, bit odd, bit pb, bit stopb);
      rec_t r;
      int   mask;
      logic [7:0] m;
      mask   = (1 << n) - 1;
      m      = d & mask[7:0];
      r.dat  = m;
      r.perr = pen && ((($countones(m) + int'(pb)) % 2) != int'(odd));
      r.serr = !stopb;
      r.brk  = 1'b0;
      if (!stopb && m == 8'h00 && (!pen || !pb)) begin
         r     = '0;
         r.brk = 1'b1;
      end
      return r;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_rec(string name, rec_t exp);
      int t;
      t = 0;
      while (got_q.size() == 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (got_q.size() == 0) begin
         errors++;
         $display("FAIL %s: no word received, required dat=%h p=%b s=%b b=%b",
                  name, exp.dat, exp.perr, exp.serr, exp.brk);
      end else begin
         rec_t g;
         g = got_q.pop_front();
         if (g !== exp) begin
            errors++;
            $display("FAIL %s: got dat=%h p=%b s=%b b=%b required dat=%h p=%b s=%b b=%b",
                     name, g.dat, g.perr, g.serr, g.brk, exp.dat, exp.perr, exp.serr, exp.brk);
         end
      end
   endtask

   task automatic wait_ticks(int n);
      int k;
      k = 0;
      while (k < n) begin
         @(posedge clk);
         if (sample_tick) k++;
      end
   endtask

   task automatic idle(int nbits);
      serial_data_in = 1'b1;
      wait_ticks(nbits * OS);
      #1;
   endtask

   task automatic set_cfg(logic [3:0] nb, bit pen, bit odd, bit two);
      cfg_data_bits  = nb;
      cfg_parity_en  = pen;
      cfg_parity_odd = odd;
      cfg_two_stop   = two;
   endtask

   task automatic build(logic [7:0] d, int n, bit pen, bit pb, bit two, bit stopb);
      txq.delete();
      txq.push_back(1'b0);
      for (int i = 0; i < n; i++) txq.push_back(d[i]);
      if (pen) txq.push_back(pb);
      txq.push_back(stopb);
      if (two) txq.push_back(1'b1);
   endtask

   // Drives txq, one line value per tick. ready_idx raises rx_ready one clk before that tick's
   // edge, glitch_idx forces a single low tick, max_ticks aborts the frame part-way.
   task automatic send_txq(int ready_idx, int glitch_idx, int max_ticks);
      int idx;
      wait_ticks(1);
      #1;
      for (int b = 0; b < txq.size(); b++) begin
         for (int j = 0; j < OS; j++) begin
            idx = b * OS + j;
            if (idx == max_ticks) return;
            if (idx == ready_idx) begin
               repeat (tdiv - 1) @(posedge clk);
               #1;
               rx_ready = 1'b1;
            end
            serial_data_in = (idx == glitch_idx) ? 1'b0 : txq[b];
            wait_ticks(1);
            #1;
         end
      end
      serial_data_in = 1'b1;
   endtask

   initial begin
      logic [7:0] rd;
      int         rn;
      bit         rpen, rodd, rtwo, rpb;
      rec_t       gl_exp;

      vecs[0] = '{4'd8,  8, 8'hA5, 0, 0, 0, 0, 1, '{8'hA5, 1'b0, 1'b0, 1'b0}};
      vecs[1] = '{4'd7,  7, 8'h41, 1, 0, 0, 1, 1, '{8'h41, 1'b1, 1'b0, 1'b0}};
      vecs[2] = '{4'd7,  7, 8'h42, 1, 0, 0, 0, 1, '{8'h42, 1'b0, 1'b0, 1'b0}};
      vecs[3] = '{4'd5,  5, 8'h15, 1, 1, 1, 0, 1, '{8'h15, 1'b0, 1'b0, 1'b0}};
      vecs[4] = '{4'd6,  6, 8'h3F, 1, 1, 0, 0, 1, '{8'h3F, 1'b1, 1'b0, 1'b0}};
      vecs[5] = '{4'd15, 8, 8'h3C, 0, 0, 0, 0, 1, '{8'h3C, 1'b0, 1'b0, 1'b0}};
      vecs[6] = '{4'd2,  8, 8'hC3, 0, 0, 0, 0, 1, '{8'hC3, 1'b0, 1'b0, 1'b0}};
      vecs[7] = '{4'd8,  8, 8'h81, 0, 0, 0, 0, 0, '{8'h81, 1'b0, 1'b1, 1'b0}};
      vecs[8] = '{4'd8,  8, 8'h00, 0, 0, 0, 0, 0, '{8'h00, 1'b0, 1'b0, 1'b1}};
      vecs[9] = '{4'd8,  8, 8'h80, 1, 0, 1, 1, 1, '{8'h80, 1'b0, 1'b0, 1'b0}};

      reset          = 1'b1;
      serial_data_in = 1'b1;
      rx_ready       = 1'b1;
      set_cfg(4'd8, 0, 0, 0);

      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", rx_valid, 0);
      check("rst_data", data_out, 0);
      check("rst_busy", rx_busy, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_valid", rx_valid, 0);
      check("post_rst_flags", {parity_error, stop_error, break_error, overflow_error}, 0);
      check("post_rst_busy", rx_busy, 0);
      idle(1);

      // ---- directed frame table ----
      foreach (vecs[i]) begin
         set_cfg(vecs[i].cfg_bits, vecs[i].pen, vecs[i].odd, vecs[i].two);
         build(vecs[i].dat, vecs[i].nbits, vecs[i].pen, vecs[i].pb, vecs[i].two, vecs[i].stopb);
         send_txq(-1, -1, -1);
         idle(2);
         check_rec($sformatf("vec%0d", i), vecs[i].exp);
      end
      check("vec_no_extra", got_q.size(), 0);

      // ---- randomised frames against the model ----
      for (int r = 0; r < 24; r++) begin
         tdiv = $urandom_range(1, 4);
         rn   = $urandom_range(5, 8);
         rd   = 8'($urandom);
         rpen = 1'($urandom);
         rodd = 1'($urandom);
         rtwo = 1'($urandom);
         rpb  = 1'($urandom);
         set_cfg(4'(rn), rpen, rodd, rtwo);
         build(rd, rn, rpen, rpb, rtwo, 1'b1);
         send_txq(-1, -1, -1);
         idle(1);
         check_rec($sformatf("rand%0d", r), model(rd, rn, rpen, rodd, rpb, 1'b1));
      end
      check("rand_no_extra", got_q.size(), 0);
      tdiv = 4;
      idle(1);

      // ---- single-tick glitch at bit 3 sample of 0xFF ----
      set_cfg(4'd8, 0, 0, 0);
      build(8'hFF, 8, 0, 0, 0, 1'b1);
      send_txq(-1, 4 * OS + OS / 2, -1);
      idle(2);
`ifdef UART_RX_MAJORITY_EN
      gl_exp = '{8'hFF, 1'b0, 1'b0, 1'b0};
`else
      gl_exp = '{8'hF7, 1'b0, 1'b0, 1'b0};
`endif
      check_rec("glitch_bit3", gl_exp);

      // ---- short low pulse: false start ----
      got_q.delete();
      wait_ticks(1);
      #1;
      serial_data_in = 1'b0;
      wait_ticks(4);
      @(negedge clk);
      check("false_start_busy", rx_busy, 1);
      serial_data_in = 1'b1;
      idle(2);
      check("false_start_idle", rx_busy, 0);
      check("false_start_noword", got_q.size(), 0);

      // ---- break: 12 bit times low ----
      wait_ticks(1);
      #1;
      serial_data_in = 1'b0;
      wait_ticks(11 * OS);
      @(negedge clk);
      check("break_wait_busy", rx_busy, 1);
      check("break_one_word", got_q.size(), 1);
      serial_data_in = 1'b1;
      idle(3);
      check("break_no_extra", got_q.size(), 1);
      check_rec("break_word", '{8'h00, 1'b0, 1'b0, 1'b1});
      check("break_idle", rx_busy, 0);

      // ---- overflow and simultaneous pop/load ----
      got_q.delete();
      ovf_cnt = 0;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      build(8'h11, 8, 0, 0, 0, 1'b1);
      send_txq(-1, -1, -1);
      idle(2);
      check("ovf_first_valid", rx_valid, 1);
      check("ovf_first_data", data_out, 8'h11);
      check("ovf_none_yet", ovf_cnt, 0);
      build(8'h22, 8, 0, 0, 0, 1'b1);
      send_txq(-1, -1, -1);
      idle(2);
      check("ovf_pulse_1clk", ovf_cnt, 1);
      check("ovf_keep_data", data_out, 8'h11);
      check("ovf_keep_valid", rx_valid, 1);
      build(8'h33, 8, 0, 0, 0, 1'b1);
      send_txq(OS / 2 + OS * 9, -1, -1);
      idle(2);
      check("simul_words", got_q.size(), 2);
      check_rec("simul_old", '{8'h11, 1'b0, 1'b0, 1'b0});
      check_rec("simul_new", '{8'h33, 1'b0, 1'b0, 1'b0});
      check("simul_no_ovf", ovf_cnt, 1);

      // ---- reset mid-DATA ----
      got_q.delete();
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      build(8'h5A, 8, 0, 0, 0, 1'b1);
      send_txq(-1, -1, -1);
      idle(1);
      check("pre_rst_valid", rx_valid, 1);
      build(8'hFF, 8, 0, 0, 0, 1'b1);
      send_txq(-1, -1, 4 * OS);
      @(negedge clk);
      check("pre_rst_busy", rx_busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_data", data_out, 0);
      check("mid_rst_valid", rx_valid, 0);
      check("mid_rst_flags", {parity_error, stop_error, break_error, overflow_error}, 0);
      check("mid_rst_busy", rx_busy, 0);
      @(posedge clk);
      #1;
      reset          = 1'b0;
      serial_data_in = 1'b1;
      rx_ready       = 1'b1;
      idle(2);
      check("post_rst_noword", got_q.size(), 0);
      build(8'h96, 8, 0, 0, 0, 1'b1);
      send_txq(-1, -1, -1);
      idle(2);
      check_rec("post_rst_frame", '{8'h96, 1'b0, 1'b0, 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
